// File: rtl/pim_cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// pim_cmd_dispatcher
//
// Queued, multi-channel command front end for the PIM matmul memory.
// Tagged commands are accepted over valid/ready into a small FIFO. Legal
// commands are issued one at a time to their target channel with a start
// pulse and a shared operand bus. Each channel is tracked for completion or
// timeout. Every command produces exactly one tagged response.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   cmd_valid / cmd_ready        command handshake (ready = FIFO not full)
//   cmd_op, cmd_ch               operation (3 = reserved) and target channel
//   cmd_src1, cmd_src2, cmd_dst  operand addresses
//   cmd_tag                      tag given to a command accepted this cycle
//   ch_start                     per-channel start, held START_CYC cycles
//   ch_op, ch_src1/2, ch_dst     operands of the last issue (shared bus)
//   ch_done                      per-channel completion pulse
//   rsp_valid/tag/ch/status      one completion per cycle (0 OK,
//                                1 TIMEOUT, 2 REJECTED), no backpressure
//   err_spurious                 sticky flag: done seen on an idle channel
// ---------------------------------------------------------------------------
module pim_cmd_dispatcher #(
    parameter int LEN         = 32,
    parameter int DEPTH       = 4,
    parameter int NUM_CH      = 2,
    parameter int START_CYC   = 1,
    parameter int TIMEOUT_CYC = 1024,
    parameter int TAG_W       = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [LEN-1:0]    cmd_src1,
    input  logic [LEN-1:0]    cmd_src2,
    input  logic [LEN-1:0]    cmd_dst,
    output logic [TAG_W-1:0]  cmd_tag,
    output logic [NUM_CH-1:0] ch_start,
    output logic [1:0]        ch_op,
    output logic [LEN-1:0]    ch_src1,
    output logic [LEN-1:0]    ch_src2,
    output logic [LEN-1:0]    ch_dst,
    input  logic [NUM_CH-1:0] ch_done,
    output logic              rsp_valid,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [CH_W-1:0]   rsp_ch,
    output logic [1:0]        rsp_status,
    output logic              err_spurious
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int SC_W  = $clog2(START_CYC + 1);

    localparam logic [1:0] OP_RSVD      = 2'd3;
    localparam logic [1:0] STS_OK       = 2'd0;
    localparam logic [1:0] STS_TIMEOUT  = 2'd1;
    localparam logic [1:0] STS_REJECTED = 2'd2;

    typedef struct packed {
        logic [1:0]       op;
        logic [CH_W-1:0]  ch;
        logic [LEN-1:0]   src1;
        logic [LEN-1:0]   src2;
        logic [LEN-1:0]   dst;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    cmd_t              fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [TAG_W-1:0]  tag_cnt;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    cmd_t              head;
    logic              head_ch_ok;
    logic              head_legal;

    state_t            state;
    state_t            state_next;
    logic [SC_W-1:0]   start_cnt;
    logic              do_issue;
    logic              do_reject;

    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] pend;
    logic [1:0]        pend_status [NUM_CH];
    logic [TAG_W-1:0]  busy_tag    [NUM_CH];
    logic [TMR_W-1:0]  timer       [NUM_CH];

    logic              rej_pend;
    logic [TAG_W-1:0]  rej_tag;
    logic [CH_W-1:0]   rej_ch;

    logic              grant_valid;
    logic [CH_W-1:0]   grant_idx;
    logic              rej_grant;

    assign push       = cmd_valid && cmd_ready;
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign cmd_tag    = tag_cnt;

    // A channel index field wider than needed can name a channel that does
    // not exist; only then is a range check required.
    generate
        if ((1 << CH_W) > NUM_CH) begin : g_ch_check
            assign head_ch_ok = (int'(head.ch) < NUM_CH);
        end else begin : g_ch_all
            assign head_ch_ok = 1'b1;
        end
    endgenerate

    assign head_legal = (head.op != OP_RSVD) && head_ch_ok;

    // Command storage. The array itself needs no reset: the pointers and
    // count decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{op: cmd_op, ch: cmd_ch, src1: cmd_src1,
                                   src2: cmd_src2, dst: cmd_dst, tag: tag_cnt};
        end
    end

    // FIFO bookkeeping and tag counter. cmd_ready is registered from the
    // post-update count, so a slot freed by a pop only shows up one cycle
    // later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            tag_cnt   <= '0;
            cmd_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                tag_cnt <= tag_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_next;
            cmd_ready <= (count_next < CNT_W'(DEPTH));
        end
    end

    // Issue decision. In IDLE the head is either issued (legal, channel
    // free), rejected (illegal, reject slot free) or left to block the
    // queue. ISSUE only times the start pulse.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        do_issue   = 1'b0;
        do_reject  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head_legal) begin
                        if (!busy[head.ch]) begin
                            pop        = 1'b1;
                            do_issue   = 1'b1;
                            state_next = ISSUE;
                        end
                    end else if (!rej_pend) begin
                        pop       = 1'b1;
                        do_reject = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (start_cnt == SC_W'(START_CYC - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, start pulse and the shared operand bus. The bus keeps
    // the last issued operands until the next issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            start_cnt <= '0;
            ch_start  <= '0;
            ch_op     <= '0;
            ch_src1   <= '0;
            ch_src2   <= '0;
            ch_dst    <= '0;
        end else begin
            state <= state_next;
            if (do_issue) begin
                start_cnt <= '0;
                ch_start  <= NUM_CH'(1) << head.ch;
                ch_op     <= head.op;
                ch_src1   <= head.src1;
                ch_src2   <= head.src2;
                ch_dst    <= head.dst;
            end else if (state == ISSUE) begin
                if (start_cnt == SC_W'(START_CYC - 1)) begin
                    ch_start <= '0;
                end else begin
                    start_cnt <= start_cnt + 1'b1;
                end
            end
        end
    end

    // Per-channel tracking. A busy channel waits for done or timeout; done
    // wins when both land on the same edge. The channel stays busy until
    // its response has been emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            pend <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                pend_status[c] <= STS_OK;
                busy_tag[c]    <= '0;
                timer[c]       <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (do_issue && (head.ch == CH_W'(c))) begin
                    busy[c]     <= 1'b1;
                    pend[c]     <= 1'b0;
                    timer[c]    <= '0;
                    busy_tag[c] <= head.tag;
                end else if (grant_valid && (grant_idx == CH_W'(c))) begin
                    busy[c] <= 1'b0;
                    pend[c] <= 1'b0;
                end else if (busy[c] && !pend[c]) begin
                    if (ch_done[c]) begin
                        pend[c]        <= 1'b1;
                        pend_status[c] <= STS_OK;
                    end else if (timer[c] == TMR_W'(TIMEOUT_CYC - 1)) begin
                        pend[c]        <= 1'b1;
                        pend_status[c] <= STS_TIMEOUT;
                    end else begin
                        timer[c] <= timer[c] + 1'b1;
                    end
                end
            end
        end
    end

    // Single-entry slot holding a rejected command until it is reported,
    // plus the sticky spurious-done flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_pend     <= 1'b0;
            rej_tag      <= '0;
            rej_ch       <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (do_reject) begin
                rej_pend <= 1'b1;
                rej_tag  <= head.tag;
                rej_ch   <= head.ch;
            end else if (rej_grant) begin
                rej_pend <= 1'b0;
            end
            if ((ch_done & ~busy) != '0) begin
                err_spurious <= 1'b1;
            end
        end
    end

    // Fixed-priority arbiter: scanning from the top down leaves the lowest
    // pending channel as the winner. The reject slot only goes out when no
    // channel is pending.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pend[c]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(c);
            end
        end
    end

    assign rej_grant = !grant_valid && rej_pend;

    // Response outputs are decoded straight from the pending state so that
    // they read as zero whenever nothing is being reported.
    always_comb begin
        rsp_valid  = grant_valid || rej_pend;
        rsp_tag    = '0;
        rsp_ch     = '0;
        rsp_status = STS_OK;
        if (grant_valid) begin
            rsp_tag    = busy_tag[grant_idx];
            rsp_ch     = grant_idx;
            rsp_status = pend_status[grant_idx];
        end else if (rej_pend) begin
            rsp_tag    = rej_tag;
            rsp_ch     = rej_ch;
            rsp_status = STS_REJECTED;
        end
    end

endmodule

// File: tb/tb_pim_cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_pim_cmd_dispatcher
//
// Directed scenarios for reset, single issue, FIFO full/ready timing,
// timeout, simultaneous completions, rejection, spurious done and reset in
// flight, followed by a randomized phase scored against a transaction-level
// reference model (queue of accepted commands, per-channel in-flight record).
// ---------------------------------------------------------------------------
module tb_pim_cmd_dispatcher;

    localparam int LEN         = 32;
    localparam int DEPTH       = 4;
    localparam int NUM_CH      = 2;
    localparam int START_CYC   = 1;
    localparam int TIMEOUT_CYC = 16;
    localparam int TAG_W       = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic              cmd_ch;
    logic [LEN-1:0]    cmd_src1;
    logic [LEN-1:0]    cmd_src2;
    logic [LEN-1:0]    cmd_dst;
    logic [TAG_W-1:0]  cmd_tag;
    logic [NUM_CH-1:0] ch_start;
    logic [1:0]        ch_op;
    logic [LEN-1:0]    ch_src1;
    logic [LEN-1:0]    ch_src2;
    logic [LEN-1:0]    ch_dst;
    logic [NUM_CH-1:0] ch_done;
    logic              rsp_valid;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_ch;
    logic [1:0]        rsp_status;
    logic              err_spurious;

    logic [NUM_CH-1:0] dirDone;
    logic [NUM_CH-1:0] mdlDone;
    assign ch_done = dirDone | mdlDone;

    pim_cmd_dispatcher #(
        .LEN(LEN), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .START_CYC(START_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ch(cmd_ch), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
        .cmd_dst(cmd_dst), .cmd_tag(cmd_tag),
        .ch_start(ch_start), .ch_op(ch_op), .ch_src1(ch_src1),
        .ch_src2(ch_src2), .ch_dst(ch_dst), .ch_done(ch_done),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_ch(rsp_ch),
        .rsp_status(rsp_status), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge it equals the index of the last posedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]       op;
        logic             ch;
        logic [LEN-1:0]   s1;
        logic [LEN-1:0]   s2;
        logic [LEN-1:0]   d;
        logic [TAG_W-1:0] tag;
    } cmdRec;

    cmdRec            cmdQ[$];
    logic [TAG_W-1:0] tagExp;
    bit               modelOn;
    logic [NUM_CH-1:0] prevStart;
    bit               flightOn  [NUM_CH];
    logic [TAG_W-1:0] flightTag [NUM_CH];
    int               issueCyc  [NUM_CH];
    int               doneAt    [NUM_CH];

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offers one command starting at the current negedge; returns at the
    // negedge after the accepting posedge with cmd_valid still high.
    task automatic applyStimulus(input logic [1:0] op, input logic ch,
                                 input logic [LEN-1:0] s1,
                                 input logic [LEN-1:0] s2,
                                 input logic [LEN-1:0] d);
        int w;
        cmdRec r;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ch    = ch;
        cmd_src1  = s1;
        cmd_src2  = s2;
        cmd_dst   = d;
        w = 0;
        while (!cmd_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            checkOutput("acceptTimeout", cmd_ready, 1);
            cmd_valid = 1'b0;
        end else begin
            checkOutput("cmdTag", cmd_tag, tagExp);
            r.op = op; r.ch = ch; r.s1 = s1; r.s2 = s2; r.d = d; r.tag = tagExp;
            cmdQ.push_back(r);
            tagExp++;
            @(negedge clk);
        end
    endtask

    task automatic clearModel();
        cmdQ.delete();
        tagExp    = '0;
        prevStart = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            flightOn[c] = 1'b0;
            doneAt[c]   = -1;
        end
    endtask

    task automatic resetDut();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        dirDone   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clearModel();
    endtask

    // Reference model step, one per negedge: score responses and issues
    // against the accepted-command queue and schedule done pulses.
    task automatic modelStep();
        int c;
        int idx;
        int d;
        int refCyc;
        logic [NUM_CH-1:0] rising;
        mdlDone = '0;
        if (rsp_valid) begin
            if (rsp_status == 2'd2) begin
                if (cmdQ.size() > 0 && cmdQ[0].op == 2'd3) begin
                    checkOutput("rejTag", rsp_tag, cmdQ[0].tag);
                    checkOutput("rejCh", rsp_ch, cmdQ[0].ch);
                    void'(cmdQ.pop_front());
                end else begin
                    checkOutput("rejExpected", rsp_status, 0);
                end
            end else begin
                c = int'(rsp_ch);
                checkOutput("rspInflight", flightOn[c], 1);
                if (flightOn[c]) begin
                    checkOutput("rspTag", rsp_tag, flightTag[c]);
                    checkOutput("rspStatus", rsp_status, (doneAt[c] >= 0) ? 0 : 1);
                    refCyc = (doneAt[c] >= 0) ? doneAt[c] : issueCyc[c] + TIMEOUT_CYC;
                    checkOutput("rspTiming", (cyc >= refCyc) && (cyc <= refCyc + 2), 1);
                    flightOn[c] = 1'b0;
                end
            end
        end
        checkOutput("startWidth", ch_start & prevStart, 0);
        rising = ch_start & ~prevStart;
        if (rising != '0) begin
            checkOutput("startOneHot", $onehot(rising), 1);
            c = rising[1] ? 1 : 0;
            idx = -1;
            for (int i = 0; i < cmdQ.size(); i++) begin
                if (idx < 0 && cmdQ[i].op != 2'd3) idx = i;
            end
            if (idx < 0) begin
                checkOutput("issueExpected", ch_start, 0);
            end else begin
                checkOutput("issueCh", c, cmdQ[idx].ch);
                checkOutput("issueOp", ch_op, cmdQ[idx].op);
                checkOutput("issueSrc1", ch_src1, cmdQ[idx].s1);
                checkOutput("issueSrc2", ch_src2, cmdQ[idx].s2);
                checkOutput("issueDst", ch_dst, cmdQ[idx].d);
                checkOutput("issueChFree", flightOn[c], 0);
                flightOn[c]  = 1'b1;
                flightTag[c] = cmdQ[idx].tag;
                issueCyc[c]  = cyc;
                d = int'($urandom_range(1, 24));
                doneAt[c] = (d <= TIMEOUT_CYC) ? cyc + d : -1;
                cmdQ.delete(idx);
            end
        end
        prevStart = ch_start;
        for (int k = 0; k < NUM_CH; k++) begin
            if (flightOn[k] && doneAt[k] == cyc + 1) mdlDone[k] = 1'b1;
        end
    endtask

    initial begin
        mdlDone = '0;
        forever begin
            @(negedge clk);
            if (modelOn) modelStep();
        end
    end

    initial begin
        int w;
        int t0;
        int tr;
        bit sawAct;
        logic [1:0] op;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ch = 1'b0;
        cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0; dirDone = '0;
        modelOn = 1'b0;
        clearModel();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset values
        checkOutput("rstReady", cmd_ready, 1);
        checkOutput("rstTag", cmd_tag, 0);
        checkOutput("rstStart", ch_start, 0);
        checkOutput("rstRsp", rsp_valid, 0);
        checkOutput("rstErr", err_spurious, 0);
        checkOutput("rstBus", ch_src1, 0);

        // Single MATMUL on ch0, done 10 cycles after start
        applyStimulus(2'd0, 1'b0, 32'd0, 32'd64, 32'd128);
        cmd_valid = 1'b0;
        checkOutput("t1NoStartYet", ch_start, 0);
        @(negedge clk);
        checkOutput("t1Start", ch_start, 2'b01);
        checkOutput("t1Op", ch_op, 0);
        checkOutput("t1Src2", ch_src2, 64);
        checkOutput("t1Dst", ch_dst, 128);
        @(negedge clk);
        checkOutput("t1StartLen", ch_start, 0);
        repeat (8) @(negedge clk);
        checkOutput("t1NoRspEarly", rsp_valid, 0);
        dirDone = 2'b01;
        @(negedge clk);
        dirDone = '0;
        checkOutput("t1RspValid", rsp_valid, 1);
        checkOutput("t1RspTag", rsp_tag, 0);
        checkOutput("t1RspCh", rsp_ch, 0);
        checkOutput("t1RspStatus", rsp_status, 0);
        @(negedge clk);
        checkOutput("t1RspPulse", rsp_valid, 0);

        // Fill FIFO behind a busy channel, then let the head time out
        applyStimulus(2'd0, 1'b0, 32'h100, 32'h1, 32'h2);
        cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("t2Issue", ch_start, 2'b01);
        t0 = cyc;
        for (int k = 2; k <= 5; k++) begin
            applyStimulus(2'd1, 1'b0, 32'h100 * k, 32'h1, 32'h2);
        end
        cmd_valid = 1'b0;
        checkOutput("t2ReadyLow", cmd_ready, 0);
        w = 0;
        while (!rsp_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        checkOutput("t2RspSeen", rsp_valid, 1);
        checkOutput("t2TimeoutLat", cyc - t0, TIMEOUT_CYC);
        checkOutput("t2Status", rsp_status, 1);
        checkOutput("t2Tag", rsp_tag, 1);
        checkOutput("t2ReadyStill", cmd_ready, 0);
        @(negedge clk);
        checkOutput("t2ReadyHeld", cmd_ready, 0);
        @(negedge clk);
        checkOutput("t2Reissue", ch_start, 2'b01);
        checkOutput("t2ReissueSrc", ch_src1, 32'h200);
        checkOutput("t2ReadyBack", cmd_ready, 1);

        // Reset while issuing with three commands still queued
        rst = 1'b1;
        #1;
        checkOutput("t6StartDrop", ch_start, 0);
        checkOutput("t6NoRsp", rsp_valid, 0);
        checkOutput("t6Ready", cmd_ready, 1);
        checkOutput("t6Tag", cmd_tag, 0);
        @(negedge clk);
        rst = 1'b0;
        clearModel();
        sawAct = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ch_start != '0 || rsp_valid) sawAct = 1'b1;
        end
        checkOutput("t6Quiet", sawAct, 0);

        // ch0 and ch1 complete on the same cycle
        applyStimulus(2'd0, 1'b0, 32'h10, 32'h20, 32'h30);
        applyStimulus(2'd1, 1'b1, 32'h40, 32'h50, 32'h60);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        dirDone = 2'b11;
        @(negedge clk);
        dirDone = '0;
        checkOutput("t3Rsp0Valid", rsp_valid, 1);
        checkOutput("t3Rsp0Ch", rsp_ch, 0);
        checkOutput("t3Rsp0Tag", rsp_tag, 0);
        checkOutput("t3Rsp0Status", rsp_status, 0);
        @(negedge clk);
        checkOutput("t3Rsp1Valid", rsp_valid, 1);
        checkOutput("t3Rsp1Ch", rsp_ch, 1);
        checkOutput("t3Rsp1Tag", rsp_tag, 1);
        @(negedge clk);
        checkOutput("t3RspEnd", rsp_valid, 0);

        // Reserved op rejected, following legal command issued normally
        applyStimulus(2'd3, 1'b1, 32'h7, 32'h8, 32'h9);
        applyStimulus(2'd2, 1'b1, 32'd100, 32'd200, 32'd300);
        cmd_valid = 1'b0;
        checkOutput("t5RejValid", rsp_valid, 1);
        checkOutput("t5RejStatus", rsp_status, 2);
        checkOutput("t5RejTag", rsp_tag, 2);
        checkOutput("t5RejCh", rsp_ch, 1);
        checkOutput("t5RejNoStart", ch_start, 0);
        @(negedge clk);
        checkOutput("t5Start", ch_start, 2'b10);
        checkOutput("t5Src1", ch_src1, 100);
        checkOutput("t5Op", ch_op, 2);
        checkOutput("t5RejPulse", rsp_valid, 0);
        repeat (3) @(negedge clk);
        dirDone = 2'b10;
        @(negedge clk);
        dirDone = '0;
        checkOutput("t5RspTag", rsp_tag, 3);
        checkOutput("t5RspStatus", rsp_status, 0);
        checkOutput("t5ErrClear", err_spurious, 0);
        @(negedge clk);
        dirDone = 2'b10;
        @(negedge clk);
        dirDone = '0;
        checkOutput("t5ErrSet", err_spurious, 1);
        checkOutput("t5StrayNoRsp", rsp_valid, 0);
        repeat (3) @(negedge clk);
        checkOutput("t5ErrSticky", err_spurious, 1);

        resetDut();
        checkOutput("t7ErrCleared", err_spurious, 0);

        // Randomized traffic against the reference model
        modelOn = 1'b1;
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            applyStimulus(op, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
            cmd_valid = 1'b0;
            tr = int'($urandom_range(0, 3));
            repeat (tr) @(negedge clk);
        end
        w = 0;
        while ((cmdQ.size() != 0 || flightOn[0] || flightOn[1]) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        checkOutput("drainDone", (cmdQ.size() == 0) && !flightOn[0] && !flightOn[1], 1);
        repeat (2) @(negedge clk);
        modelOn = 1'b0;
        checkOutput("randNoSpurious", err_spurious, 0);
        checkOutput("randIdleRsp", rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
